image_capture_buffer: RTL
=========================

IMAGE_CAPTURE_BUFFER -- requirements
Module: image_capture_buffer

Interface
REQ-001 SHALL have parameter THRESHOLD, default 8'd128; grayscale binarization threshold.
REQ-002 SHALL have parameter TIMEOUT, default 16'd60000; max cycles to wait for tpu_done.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pix_valid  input  1  upstream pixel valid.
REQ-006 SHALL have port pix_ready  output  1  buffer accepts a pixel this cycle.
REQ-007 SHALL have port pix_data  input  8  grayscale pixel, row-major order.
REQ-008 SHALL have port pix_last  input  1  marks final pixel of a frame.
REQ-009 SHALL have port image_out  output  1024  packed binary image to TPU; bit k = pixel k = row*32+col.
REQ-010 SHALL have port tpu_ena  output  1  TPU enable.
REQ-011 SHALL have port tpu_rstn  output  1  TPU synchronous reset, active-low.
REQ-012 SHALL have port tpu_done / tpu_num / tpu_overflow  input  1/4/1  TPU status, digit, overflow.
REQ-013 SHALL have port result  output  4  last classified digit.
REQ-014 SHALL have port result_valid / result_overflow / frame_err / busy  output  1 each  result strobe, overflow flag, error strobe, TPU run in progress.

Function
REQ-015 SHALL implement states FILL, TPU_RST, RUN, RESULT; transfer = pix_valid & pix_ready; pix_ready registered, 1 only in FILL.
REQ-016 On transfer SHALL write bit idx of image_out = (pix_data >= THRESHOLD), then idx increments; idx is 10 bits.
REQ-017 Transfer with idx==1023 and pix_last==1 SHALL complete frame: FILL->TPU_RST, pix_ready 0 next cycle.
REQ-018 Transfer with pix_last==1 at idx<1023, or pix_last==0 at idx==1023, SHALL pulse frame_err 1 cycle, set idx=0, stay in FILL, not launch TPU.
REQ-019 TPU_RST SHALL last exactly 2 cycles with tpu_ena=1, tpu_rstn=0; then RUN with tpu_rstn=1.
REQ-020 RUN SHALL hold tpu_ena=1, busy=1, count cycles; tpu_done==1 -> RESULT.
REQ-021 RUN count reaching TIMEOUT without tpu_done SHALL pulse frame_err, set result=4'hF, result_overflow=0, go to RESULT without latching TPU outputs.
REQ-022 RESULT (1 cycle) SHALL latch result=tpu_num, result_overflow=tpu_overflow (unless timeout), pulse result_valid 1 cycle, set idx=0, go to FILL.
REQ-023 tpu_ena SHALL be 0 in FILL; image_out SHALL not change outside FILL.
REQ-024 result and result_overflow SHALL hold until next RESULT; pix_valid outside FILL SHALL be ignored.

Reset
REQ-025 iRst_n low SHALL immediately force: state FILL, idx 0, image_out 0, pix_ready 0, tpu_ena 0, tpu_rstn 1, result 4'hF, result_valid 0, result_overflow 0, frame_err 0, busy 0, timeout counter 0.
REQ-026 pix_ready SHALL rise on first clk edge after iRst_n deasserts; reset mid-frame or mid-RUN SHALL abandon it with no result_valid.

Configuration
REQ-027 Macro BINARIZE_INVERT_EN defined: bit = (pix_data < THRESHOLD) (dark ink = 1); undefined: bit = (pix_data >= THRESHOLD); nothing else changes.

Verification
REQ-028 1024 pixels all 8'hFF, pix_last on #1023 -> image_out all ones, tpu_rstn low 2 cycles, busy high; tpu_done=1,tpu_num=7 -> result=7, result_valid 1 cycle.
REQ-029 Pixel k = (k even ? 8'd200 : 8'd50) -> image_out = {512{2'b01}}; with BINARIZE_INVERT_EN -> {512{2'b10}}.
REQ-030 pix_last at pixel #500 -> frame_err 1 cycle, tpu_ena stays 0, next full frame accepted from bit 0.
REQ-031 TIMEOUT=100, tpu_done held 0 -> frame_err at cycle 100 of RUN, result=4'hF, result_valid pulse, back to FILL.
REQ-032 iRst_n low during RUN -> all outputs to REQ-025 values asynchronously, no result_valid; pix_ready 1 one cycle after release.
REQ-033 pix_valid toggling randomly 50%, pixel 8'd128 -> bit 1 (threshold inclusive); tpu_overflow=1 at done -> result_overflow=1.

Source files
------------

// File: rtl/image_capture_buffer.sv
// Image capture buffer: binarizes a 32x32 grayscale frame and runs the TPU on it.
// Optional BINARIZE_INVERT_EN: dark pixels (below THRESHOLD) become 1 bits.
module image_capture_buffer #(
    parameter logic [7:0]  THRESHOLD = 8'd128,
    parameter logic [15:0] TIMEOUT   = 16'd60000
) (
    input  logic          clk,
    input  logic          iRst_n,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [7:0]    pix_data,
    input  logic          pix_last,
    output logic [1023:0] image_out,
    output logic          tpu_ena,
    output logic          tpu_rstn,
    input  logic          tpu_done,
    input  logic [3:0]    tpu_num,
    input  logic          tpu_overflow,
    output logic [3:0]    result,
    output logic          result_valid,
    output logic          result_overflow,
    output logic          frame_err,
    output logic          busy
);

    typedef enum logic [1:0] {
        FILL,
        TPU_RST,
        RUN,
        RESULT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [9:0]  idx;
    logic        rst_cnt;
    logic [15:0] to_cnt;
    logic        timed_out;
    logic        xfer;
    logic        pix_bit;
    logic        at_end;
    logic        frame_ok;
    logic        frame_bad;
    logic        run_expire;

    assign xfer = pix_valid & pix_ready;

`ifdef BINARIZE_INVERT_EN
    assign pix_bit = (pix_data < THRESHOLD);
`else
    assign pix_bit = (pix_data >= THRESHOLD);
`endif

    assign at_end     = (idx == 10'd1023);
    assign frame_ok   = xfer & pix_last & at_end;
    assign frame_bad  = xfer & (pix_last ^ at_end);
    assign run_expire = (state == RUN) & ~tpu_done
                      & (to_cnt == TIMEOUT - 16'd1);

    // Next-state and state-decoded TPU control outputs
    always_comb begin
        state_n  = state;
        tpu_ena  = 1'b0;
        tpu_rstn = 1'b1;
        busy     = 1'b0;
        unique case (state)
            FILL: begin
                if (frame_ok)
                    state_n = TPU_RST;
            end
            TPU_RST: begin
                tpu_ena  = 1'b1;
                tpu_rstn = 1'b0;
                if (rst_cnt)
                    state_n = RUN;
            end
            RUN: begin
                tpu_ena = 1'b1;
                busy    = 1'b1;
                if (tpu_done || run_expire)
                    state_n = RESULT;
            end
            RESULT: begin
                tpu_ena = 1'b1;
                state_n = FILL;
            end
            default: state_n = FILL;
        endcase
    end

    // State register; pix_ready is registered and tracks the next state
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= FILL;
            pix_ready <= 1'b0;
        end else begin
            state     <= state_n;
            pix_ready <= (state_n == FILL);
        end
    end

    // Pixel write pointer and binary image store
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            idx       <= 10'd0;
            image_out <= '0;
        end else if (xfer) begin
            image_out[idx] <= pix_bit;
            idx            <= frame_bad ? 10'd0 : idx + 10'd1;
        end else if (state == RESULT) begin
            idx <= 10'd0;
        end
    end

    // TPU reset length counter and RUN watchdog
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            rst_cnt   <= 1'b0;
            to_cnt    <= 16'd0;
            timed_out <= 1'b0;
        end else begin
            rst_cnt <= (state == TPU_RST) ? ~rst_cnt : 1'b0;
            to_cnt  <= (state == RUN) ? to_cnt + 16'd1 : 16'd0;
            if (state == RUN)
                timed_out <= run_expire;
        end
    end

    // Result capture and status strobes
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            result          <= 4'hF;
            result_overflow <= 1'b0;
            result_valid    <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            result_valid <= (state == RESULT);
            frame_err    <= frame_bad | run_expire;
            if (state == RESULT) begin
                result          <= timed_out ? 4'hF : tpu_num;
                result_overflow <= timed_out ? 1'b0 : tpu_overflow;
            end
        end
    end

endmodule
